rggen_backdoor_access_arbiter: RTL and testbench
================================================

Name: rggen_backdoor_access_arbiter

Overview:
- Sits directly downstream of the per-register backdoor stage. Merges the frontdoor bus access and the backdoor access into a single register-field access port.
- Produces the frontdoor ready that the backdoor stage samples for its pending logic. Consumes the backdoor stage's valid, pending and mask/data outputs, and returns its read data.
- Frontdoor transfers are never interrupted. A backdoor access runs only while no frontdoor transfer is in flight, using a 4-phase valid/done handshake.

Parameters:
- DATA_WIDTH, 32, width of data and mask buses.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_frontdoor_valid  input  1  frontdoor request; held until o_frontdoor_ready
- i_frontdoor_write  input  1  1=write, 0=read
- i_frontdoor_mask  input  DATA_WIDTH  byte/bit enable of frontdoor access
- i_frontdoor_data  input  DATA_WIDTH  frontdoor write data
- o_frontdoor_ready  output  1  frontdoor completion pulse; also feeds backdoor stage i_frontdoor_ready
- o_frontdoor_read_data  output  DATA_WIDTH  frontdoor read data, valid with o_frontdoor_ready
- i_backdoor_valid  input  1  backdoor request from backdoor stage
- i_pending_valid  input  1  backdoor stage pending flag (frontdoor in flight)
- i_backdoor_read_mask  input  DATA_WIDTH  backdoor read mask
- i_backdoor_write_mask  input  DATA_WIDTH  backdoor write mask
- i_backdoor_write_data  input  DATA_WIDTH  backdoor write data
- o_backdoor_done  output  1  backdoor access complete; held until i_backdoor_valid drops
- o_backdoor_read_data  output  DATA_WIDTH  captured backdoor read data; drives backdoor stage i_read_data
- o_access_valid  output  1  register access request
- o_access_read_mask  output  DATA_WIDTH  read mask to fields
- o_access_write_mask  output  DATA_WIDTH  write mask to fields
- o_access_write_data  output  DATA_WIDTH  write data to fields
- i_access_ready  input  1  field access completion
- i_access_read_data  input  DATA_WIDTH  field read data, valid with i_access_ready

Behaviour:
- FSM states: IDLE, FRONT, BACK, BACK_DONE. Reset state is IDLE.
- Reset values: o_access_valid=0; all access masks and data=0; o_backdoor_done=0; o_backdoor_read_data=0.
- IDLE transitions:
  - If i_frontdoor_valid: go to FRONT (frontdoor always wins in IDLE).
  - Else if i_backdoor_valid && !i_pending_valid && !o_backdoor_done: go to BACK.
  - Else stay in IDLE.
- Capture on IDLE exit: request fields are registered on the exit edge, and o_access_valid=1 from the next cycle.
  - Frontdoor write: write_mask=mask, write_data=data, read_mask=0.
  - Frontdoor read: read_mask=mask, write_mask=0, write_data=0.
  - Backdoor: read_mask, write_mask and write_data are taken as given.
- Capture latency: one cycle from request acceptance to o_access_valid.
- FRONT:
  - o_frontdoor_ready = i_access_ready (combinational); o_frontdoor_read_data = i_access_read_data (passthrough).
  - On i_access_ready: o_access_valid and the masks clear at the next edge, and the FSM returns to IDLE.
- BACK:
  - o_frontdoor_ready=0.
  - On i_access_ready: register i_access_read_data into o_backdoor_read_data, set o_backdoor_done=1, clear the access outputs, go to BACK_DONE.
- BACK_DONE:
  - Hold o_backdoor_done and o_backdoor_read_data.
  - When i_backdoor_valid=0: clear o_backdoor_done and return to IDLE. o_backdoor_read_data retains its value.
  - A frontdoor request arriving here waits for IDLE.
- Frontdoor read data is 0 whenever o_frontdoor_ready=0.
- Simultaneous frontdoor and backdoor valid in IDLE: frontdoor is granted. The backdoor stage then sets pending, and the backdoor is granted in the first IDLE cycle after frontdoor completion with pending clear.
- Backdoor valid with pending=1 in IDLE (pending lags ready by one cycle): the backdoor is not granted that cycle.
- Backdoor valid dropping while in BACK: the access still completes, and BACK_DONE exits immediately on the next cycle.
- i_access_ready in IDLE or BACK_DONE: ignored.
- Asynchronous reset mid-access: all outputs return to reset values immediately. The in-flight access is abandoned and no ready or done is issued.

Test Plan:
- Frontdoor write: mask=0xFFFF_FFFF, data=0xA5A5_0001; i_access_ready 3 cycles later -> o_access_write_mask=0xFFFF_FFFF, read_mask=0, a single-cycle o_frontdoor_ready, FSM back in IDLE.
- Frontdoor read: mask=0x0000_FFFF; i_access_read_data=0x1234_5678 with ready -> o_frontdoor_read_data=0x1234_5678 in the ready cycle; write_mask=0.
- Backdoor read+write: read_mask=0xFFFF_FFFF, write_mask=0x0000_00FF, data=0x0000_003C; ready with read data 0xDEAD_BEEF -> o_backdoor_done=1 and o_backdoor_read_data=0xDEAD_BEEF held until valid drops, then done=0 one cycle later.
- Collision: frontdoor and backdoor valid in the same cycle -> frontdoor access first; backdoor o_access_valid only after o_frontdoor_ready and pending clear; no overlap of accesses.
- Backdoor held off: i_pending_valid=1 with backdoor valid in IDLE -> o_access_valid stays 0 until pending=0.
- Reset asserted during BACK before ready -> o_access_valid=0 and o_backdoor_done=0 immediately; after release the FSM is IDLE and accepts a new frontdoor read normally.

Source files
------------

// File: rtl/rggen_backdoor_access_arbiter.sv
// Merges frontdoor bus accesses and backdoor accesses onto one register-field access port.
// Frontdoor transfers are never interrupted; backdoor runs a valid/done handshake in idle gaps.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no access in flight, arbitrating frontdoor vs backdoor
// FRONT     | frontdoor access on the field port, waiting for ready
// BACK      | backdoor access on the field port, waiting for ready
// BACK_DONE | backdoor done held until backdoor valid drops
module rggen_backdoor_access_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_frontdoor_valid,
  input  logic                  i_frontdoor_write,
  input  logic [DATA_WIDTH-1:0] i_frontdoor_mask,
  input  logic [DATA_WIDTH-1:0] i_frontdoor_data,
  output logic                  o_frontdoor_ready,
  output logic [DATA_WIDTH-1:0] o_frontdoor_read_data,
  input  logic                  i_backdoor_valid,
  input  logic                  i_pending_valid,
  input  logic [DATA_WIDTH-1:0] i_backdoor_read_mask,
  input  logic [DATA_WIDTH-1:0] i_backdoor_write_mask,
  input  logic [DATA_WIDTH-1:0] i_backdoor_write_data,
  output logic                  o_backdoor_done,
  output logic [DATA_WIDTH-1:0] o_backdoor_read_data,
  output logic                  o_access_valid,
  output logic [DATA_WIDTH-1:0] o_access_read_mask,
  output logic [DATA_WIDTH-1:0] o_access_write_mask,
  output logic [DATA_WIDTH-1:0] o_access_write_data,
  input  logic                  i_access_ready,
  input  logic [DATA_WIDTH-1:0] i_access_read_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FRONT     = 2'd1,
    BACK      = 2'd2,
    BACK_DONE = 2'd3
  } state_e;

  state_e                state;
  state_e                state_next;
  logic [DATA_WIDTH-1:0] read_mask;
  logic [DATA_WIDTH-1:0] read_mask_next;
  logic [DATA_WIDTH-1:0] write_mask;
  logic [DATA_WIDTH-1:0] write_mask_next;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] write_data_next;
  logic [DATA_WIDTH-1:0] backdoor_read_data;
  logic [DATA_WIDTH-1:0] backdoor_read_data_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= IDLE;
      read_mask          <= '0;
      write_mask         <= '0;
      write_data         <= '0;
      backdoor_read_data <= '0;
    end else begin
      state              <= state_next;
      read_mask          <= read_mask_next;
      write_mask         <= write_mask_next;
      write_data         <= write_data_next;
      backdoor_read_data <= backdoor_read_data_next;
    end
  end

  always_comb begin
    state_next              = state;
    read_mask_next          = read_mask;
    write_mask_next         = write_mask;
    write_data_next         = write_data;
    backdoor_read_data_next = backdoor_read_data;
    case (state)
      IDLE: begin
        if (i_frontdoor_valid) begin
          state_next = FRONT;
          if (i_frontdoor_write) begin
            read_mask_next  = '0;
            write_mask_next = i_frontdoor_mask;
            write_data_next = i_frontdoor_data;
          end else begin
            read_mask_next  = i_frontdoor_mask;
            write_mask_next = '0;
            write_data_next = '0;
          end
        end else if (i_backdoor_valid && !i_pending_valid && !o_backdoor_done) begin
          state_next      = BACK;
          read_mask_next  = i_backdoor_read_mask;
          write_mask_next = i_backdoor_write_mask;
          write_data_next = i_backdoor_write_data;
        end
      end
      FRONT: begin
        if (i_access_ready) begin
          state_next      = IDLE;
          read_mask_next  = '0;
          write_mask_next = '0;
          write_data_next = '0;
        end
      end
      BACK: begin
        if (i_access_ready) begin
          state_next              = BACK_DONE;
          backdoor_read_data_next = i_access_read_data;
          read_mask_next          = '0;
          write_mask_next         = '0;
          write_data_next         = '0;
        end
      end
      BACK_DONE: begin
        if (!i_backdoor_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready is a passthrough so the frontdoor completes in the same cycle the fields respond.
  assign o_frontdoor_ready     = (state == FRONT) && i_access_ready;
  assign o_frontdoor_read_data = o_frontdoor_ready ? i_access_read_data : '0;
  assign o_backdoor_done       = (state == BACK_DONE);
  assign o_backdoor_read_data  = backdoor_read_data;
  assign o_access_valid        = (state == FRONT) || (state == BACK);
  assign o_access_read_mask    = read_mask;
  assign o_access_write_mask   = write_mask;
  assign o_access_write_data   = write_data;

endmodule

// File: tb/tb_rggen_backdoor_access_arbiter.sv
// Self-checking bench for rggen_backdoor_access_arbiter: directed scenarios followed by
// randomized traffic compared against a transaction-level ownership model.
module tb_rggen_backdoor_access_arbiter;
  localparam int DW = 32;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_frontdoor_valid;
  logic          i_frontdoor_write;
  logic [DW-1:0] i_frontdoor_mask;
  logic [DW-1:0] i_frontdoor_data;
  logic          o_frontdoor_ready;
  logic [DW-1:0] o_frontdoor_read_data;
  logic          i_backdoor_valid;
  logic          i_pending_valid;
  logic [DW-1:0] i_backdoor_read_mask;
  logic [DW-1:0] i_backdoor_write_mask;
  logic [DW-1:0] i_backdoor_write_data;
  logic          o_backdoor_done;
  logic [DW-1:0] o_backdoor_read_data;
  logic          o_access_valid;
  logic [DW-1:0] o_access_read_mask;
  logic [DW-1:0] o_access_write_mask;
  logic [DW-1:0] o_access_write_data;
  logic          i_access_ready;
  logic [DW-1:0] i_access_read_data;

  int passed = 0;
  int total  = 0;

  rggen_backdoor_access_arbiter #(.DATA_WIDTH(DW)) dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .i_frontdoor_valid     (i_frontdoor_valid),
    .i_frontdoor_write     (i_frontdoor_write),
    .i_frontdoor_mask      (i_frontdoor_mask),
    .i_frontdoor_data      (i_frontdoor_data),
    .o_frontdoor_ready     (o_frontdoor_ready),
    .o_frontdoor_read_data (o_frontdoor_read_data),
    .i_backdoor_valid      (i_backdoor_valid),
    .i_pending_valid       (i_pending_valid),
    .i_backdoor_read_mask  (i_backdoor_read_mask),
    .i_backdoor_write_mask (i_backdoor_write_mask),
    .i_backdoor_write_data (i_backdoor_write_data),
    .o_backdoor_done       (o_backdoor_done),
    .o_backdoor_read_data  (o_backdoor_read_data),
    .o_access_valid        (o_access_valid),
    .o_access_read_mask    (o_access_read_mask),
    .o_access_write_mask   (o_access_write_mask),
    .o_access_write_data   (o_access_write_data),
    .i_access_ready        (i_access_ready),
    .i_access_read_data    (i_access_read_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic clear_inputs();
    i_frontdoor_valid     = 1'b0;
    i_frontdoor_write     = 1'b0;
    i_frontdoor_mask      = '0;
    i_frontdoor_data      = '0;
    i_backdoor_valid      = 1'b0;
    i_pending_valid       = 1'b0;
    i_backdoor_read_mask  = '0;
    i_backdoor_write_mask = '0;
    i_backdoor_write_data = '0;
    i_access_ready        = 1'b0;
    i_access_read_data    = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    total++; if (o_access_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_access_valid); else passed++;
    total++; if ({o_access_read_mask, o_access_write_mask, o_access_write_data} !== '0)
      $display("FAIL reset_access got %h/%h/%h want 0", o_access_read_mask, o_access_write_mask, o_access_write_data); else passed++;
    total++; if (o_backdoor_done !== 1'b0 || o_backdoor_read_data !== '0)
      $display("FAIL reset_backdoor got %b/%h want 0/0", o_backdoor_done, o_backdoor_read_data); else passed++;
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_front_write();
    i_frontdoor_valid = 1'b1; i_frontdoor_write = 1'b1;
    i_frontdoor_mask = 32'hFFFF_FFFF; i_frontdoor_data = 32'hA5A5_0001;
    #1;
    total++; if (o_access_valid !== 1'b0) $display("FAIL fw_latency got %b want 0", o_access_valid); else passed++;
    @(negedge i_clk);
    total++; if (o_access_valid !== 1'b1 || o_access_write_mask !== 32'hFFFF_FFFF || o_access_read_mask !== '0 || o_access_write_data !== 32'hA5A5_0001)
      $display("FAIL fw_capture got v=%b wm=%h rm=%h wd=%h want 1/ffffffff/0/a5a50001", o_access_valid, o_access_write_mask, o_access_read_mask, o_access_write_data); else passed++;
    @(negedge i_clk); @(negedge i_clk);
    total++; if (o_frontdoor_ready !== 1'b0) $display("FAIL fw_early_ready got %b want 0", o_frontdoor_ready); else passed++;
    @(negedge i_clk);
    i_access_ready = 1'b1; #1;
    total++; if (o_frontdoor_ready !== 1'b1) $display("FAIL fw_ready got %b want 1", o_frontdoor_ready); else passed++;
    @(negedge i_clk);
    i_access_ready = 1'b0; i_frontdoor_valid = 1'b0; #1;
    total++; if (o_frontdoor_ready !== 1'b0 || o_access_valid !== 1'b0 || o_access_write_mask !== '0)
      $display("FAIL fw_complete got r=%b v=%b wm=%h want 0/0/0", o_frontdoor_ready, o_access_valid, o_access_write_mask); else passed++;
    @(negedge i_clk);
    total++; if (o_access_valid !== 1'b0) $display("FAIL fw_idle got %b want 0", o_access_valid); else passed++;
  endtask

  task automatic test_front_read(input string tag);
    i_frontdoor_valid = 1'b1; i_frontdoor_write = 1'b0;
    i_frontdoor_mask = 32'h0000_FFFF; i_frontdoor_data = 32'h5555_AAAA;
    @(negedge i_clk);
    total++; if (o_access_valid !== 1'b1 || o_access_read_mask !== 32'h0000_FFFF || o_access_write_mask !== '0 || o_access_write_data !== '0)
      $display("FAIL %s_capture got v=%b rm=%h wm=%h wd=%h want 1/0000ffff/0/0", tag, o_access_valid, o_access_read_mask, o_access_write_mask, o_access_write_data); else passed++;
    i_access_read_data = 32'h1234_5678; #1;
    total++; if (o_frontdoor_read_data !== '0) $display("FAIL %s_rdata_idle got %h want 0", tag, o_frontdoor_read_data); else passed++;
    i_access_ready = 1'b1; #1;
    total++; if (o_frontdoor_ready !== 1'b1 || o_frontdoor_read_data !== 32'h1234_5678)
      $display("FAIL %s_rdata got r=%b d=%h want 1/12345678", tag, o_frontdoor_ready, o_frontdoor_read_data); else passed++;
    @(negedge i_clk);
    i_access_ready = 1'b0; i_frontdoor_valid = 1'b0; i_access_read_data = '0;
    @(negedge i_clk);
  endtask

  task automatic test_back_rw();
    i_backdoor_valid = 1'b1; i_backdoor_read_mask = 32'hFFFF_FFFF;
    i_backdoor_write_mask = 32'h0000_00FF; i_backdoor_write_data = 32'h0000_003C;
    @(negedge i_clk);
    total++; if (o_access_valid !== 1'b1 || o_access_read_mask !== 32'hFFFF_FFFF || o_access_write_mask !== 32'h0000_00FF || o_access_write_data !== 32'h0000_003C)
      $display("FAIL bd_capture got v=%b rm=%h wm=%h wd=%h", o_access_valid, o_access_read_mask, o_access_write_mask, o_access_write_data); else passed++;
    i_access_ready = 1'b1; i_access_read_data = 32'hDEAD_BEEF; #1;
    total++; if (o_frontdoor_ready !== 1'b0) $display("FAIL bd_no_fready got %b want 0", o_frontdoor_ready); else passed++;
    @(negedge i_clk);
    i_access_ready = 1'b0; i_access_read_data = '0;
    total++; if (o_backdoor_done !== 1'b1 || o_backdoor_read_data !== 32'hDEAD_BEEF || o_access_valid !== 1'b0)
      $display("FAIL bd_done got d=%b rd=%h v=%b want 1/deadbeef/0", o_backdoor_done, o_backdoor_read_data, o_access_valid); else passed++;
    @(negedge i_clk);
    total++; if (o_backdoor_done !== 1'b1 || o_backdoor_read_data !== 32'hDEAD_BEEF || o_access_valid !== 1'b0)
      $display("FAIL bd_hold got d=%b rd=%h v=%b want 1/deadbeef/0", o_backdoor_done, o_backdoor_read_data, o_access_valid); else passed++;
    i_backdoor_valid = 1'b0; #1;
    total++; if (o_backdoor_done !== 1'b1) $display("FAIL bd_drop_same got %b want 1", o_backdoor_done); else passed++;
    @(negedge i_clk);
    total++; if (o_backdoor_done !== 1'b0 || o_backdoor_read_data !== 32'hDEAD_BEEF)
      $display("FAIL bd_release got d=%b rd=%h want 0/deadbeef", o_backdoor_done, o_backdoor_read_data); else passed++;
  endtask

  task automatic test_collision();
    i_frontdoor_valid = 1'b1; i_frontdoor_write = 1'b0; i_frontdoor_mask = 32'h0000_F0F0;
    i_backdoor_valid = 1'b1; i_backdoor_read_mask = 32'h0F0F_0000;
    i_backdoor_write_mask = 32'h0000_0011; i_backdoor_write_data = 32'h0000_0022;
    @(negedge i_clk);
    i_pending_valid = 1'b1;
    total++; if (o_access_read_mask !== 32'h0000_F0F0 || o_access_write_mask !== '0)
      $display("FAIL col_front_first got rm=%h wm=%h want 0000f0f0/0", o_access_read_mask, o_access_write_mask); else passed++;
    i_access_ready = 1'b1; i_access_read_data = 32'h0BAD_F00D;
    @(negedge i_clk);
    i_access_ready = 1'b0; i_frontdoor_valid = 1'b0;
    total++; if (o_access_valid !== 1'b0) $display("FAIL col_gap got %b want 0", o_access_valid); else passed++;
    @(negedge i_clk);
    total++; if (o_access_valid !== 1'b0) $display("FAIL col_pending got %b want 0", o_access_valid); else passed++;
    i_pending_valid = 1'b0;
    @(negedge i_clk);
    total++; if (o_access_valid !== 1'b1 || o_access_read_mask !== 32'h0F0F_0000 || o_access_write_data !== 32'h0000_0022)
      $display("FAIL col_back got v=%b rm=%h wd=%h want 1/0f0f0000/00000022", o_access_valid, o_access_read_mask, o_access_write_data); else passed++;
    i_access_ready = 1'b1;
    @(negedge i_clk);
    i_access_ready = 1'b0; i_backdoor_valid = 1'b0;
    total++; if (o_backdoor_done !== 1'b1 || o_backdoor_read_data !== 32'h0BAD_F00D)
      $display("FAIL col_done got d=%b rd=%h want 1/0badf00d", o_backdoor_done, o_backdoor_read_data); else passed++;
    @(negedge i_clk);
    i_access_read_data = '0;
  endtask

  task automatic test_pending_holdoff();
    i_backdoor_valid = 1'b1; i_pending_valid = 1'b1; i_backdoor_read_mask = 32'h0000_0F00;
    i_backdoor_write_mask = '0; i_backdoor_write_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      total++; if (o_access_valid !== 1'b0) $display("FAIL hold_%0d got %b want 0", i, o_access_valid); else passed++;
    end
    i_pending_valid = 1'b0;
    @(negedge i_clk);
    total++; if (o_access_valid !== 1'b1 || o_access_read_mask !== 32'h0000_0F00)
      $display("FAIL hold_grant got v=%b rm=%h want 1/00000f00", o_access_valid, o_access_read_mask); else passed++;
    i_backdoor_valid = 1'b0; i_access_ready = 1'b1; i_access_read_data = 32'h0000_0A00;
    @(negedge i_clk);
    i_access_ready = 1'b0;
    total++; if (o_backdoor_done !== 1'b1) $display("FAIL hold_done got %b want 1", o_backdoor_done); else passed++;
    @(negedge i_clk);
    total++; if (o_backdoor_done !== 1'b0 || o_backdoor_read_data !== 32'h0000_0A00)
      $display("FAIL hold_exit got d=%b rd=%h want 0/00000a00", o_backdoor_done, o_backdoor_read_data); else passed++;
  endtask

  task automatic test_reset_mid_back();
    i_backdoor_valid = 1'b1; i_backdoor_read_mask = 32'h1111_1111;
    i_backdoor_write_mask = 32'h2222_2222; i_backdoor_write_data = 32'h3333_3333;
    @(negedge i_clk);
    total++; if (o_access_valid !== 1'b1) $display("FAIL rst_pre got %b want 1", o_access_valid); else passed++;
    #2 i_rst_n = 1'b0; #1;
    total++; if (o_access_valid !== 1'b0 || o_backdoor_done !== 1'b0 || o_access_write_mask !== '0 || o_backdoor_read_data !== '0)
      $display("FAIL rst_async got v=%b d=%b wm=%h rd=%h want 0/0/0/0", o_access_valid, o_backdoor_done, o_access_write_mask, o_backdoor_read_data); else passed++;
    i_access_ready = 1'b1;
    @(negedge i_clk);
    clear_inputs();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    total++; if (o_backdoor_done !== 1'b0 || o_access_valid !== 1'b0)
      $display("FAIL rst_idle got d=%b v=%b want 0/0", o_backdoor_done, o_access_valid); else passed++;
    test_front_read("rst_fr");
  endtask

  // Model tracks who owns the field port (0 none, 1 frontdoor, 2 backdoor) and the done handshake.
  task automatic test_random(input int cycles);
    int            owner = 0;
    bit            done  = 0;
    bit            front_finished = 0;
    logic [DW-1:0] m_rm = '0, m_wm = '0, m_wd = '0, m_bd = '0;
    logic          e_fr;
    logic [DW-1:0] e_frd;
    for (int c = 0; c < cycles; c++) begin
      @(negedge i_clk);
      if (front_finished) i_frontdoor_valid = 1'b0;
      else if (!i_frontdoor_valid) i_frontdoor_valid = ($urandom_range(3) == 0);
      if (done) i_backdoor_valid = i_backdoor_valid && ($urandom_range(1) == 0);
      else if (i_backdoor_valid) i_backdoor_valid = ($urandom_range(15) != 0);
      else i_backdoor_valid = ($urandom_range(3) == 0);
      i_frontdoor_write     = $urandom_range(1) == 1;
      i_frontdoor_mask      = $urandom;
      i_frontdoor_data      = $urandom;
      i_pending_valid       = ($urandom_range(3) == 0);
      i_backdoor_read_mask  = $urandom;
      i_backdoor_write_mask = $urandom;
      i_backdoor_write_data = $urandom;
      i_access_ready        = ($urandom_range(2) == 0);
      i_access_read_data    = $urandom;
      #1;
      e_fr  = (owner == 1) && i_access_ready;
      e_frd = e_fr ? i_access_read_data : '0;
      total++; if (o_access_valid !== (owner != 0)) $display("FAIL rnd_valid c=%0d got %b want %b", c, o_access_valid, owner != 0); else passed++;
      total++; if (o_access_read_mask !== m_rm || o_access_write_mask !== m_wm || o_access_write_data !== m_wd)
        $display("FAIL rnd_access c=%0d got %h/%h/%h want %h/%h/%h", c, o_access_read_mask, o_access_write_mask, o_access_write_data, m_rm, m_wm, m_wd); else passed++;
      total++; if (o_frontdoor_ready !== e_fr || o_frontdoor_read_data !== e_frd)
        $display("FAIL rnd_front c=%0d got %b/%h want %b/%h", c, o_frontdoor_ready, o_frontdoor_read_data, e_fr, e_frd); else passed++;
      total++; if (o_backdoor_done !== done || o_backdoor_read_data !== m_bd)
        $display("FAIL rnd_back c=%0d got %b/%h want %b/%h", c, o_backdoor_done, o_backdoor_read_data, done, m_bd); else passed++;
      front_finished = e_fr;
      if (owner != 0 && i_access_ready) begin
        if (owner == 2) begin done = 1; m_bd = i_access_read_data; end
        owner = 0; m_rm = '0; m_wm = '0; m_wd = '0;
      end else if (owner == 0) begin
        if (done) begin
          if (!i_backdoor_valid) done = 0;
        end else if (i_frontdoor_valid) begin
          owner = 1;
          m_rm = i_frontdoor_write ? '0 : i_frontdoor_mask;
          m_wm = i_frontdoor_write ? i_frontdoor_mask : '0;
          m_wd = i_frontdoor_write ? i_frontdoor_data : '0;
        end else if (i_backdoor_valid && !i_pending_valid) begin
          owner = 2;
          m_rm = i_backdoor_read_mask; m_wm = i_backdoor_write_mask; m_wd = i_backdoor_write_data;
        end
      end
    end
    @(negedge i_clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_front_write();
    test_front_read("fr");
    test_back_rw();
    test_collision();
    test_pending_holdoff();
    test_reset_mid_back();
    test_reset();
    test_random(600);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
